// File: rtl/alarm_pkg.sv
// Shared types and digit limits for the alarm setting controller.
// Time values are packed as [3]=hourdec, [2]=hourone, [1]=mindec, [0]=minone.
package alarm_pkg;

  typedef enum logic [1:0] {RUN = 2'd0, SET_TIME = 2'd1, SET_BUD = 2'd2} mode_e;
  typedef enum logic [1:0] {D_HOURDEC, D_HOURONE, D_MINDEC, D_MINONE} digit_e;

  typedef logic [3:0][3:0] time_t;

  localparam logic [3:0] HOURDEC_MAX    = 4'd2;
  localparam logic [3:0] HOURONE_MAX    = 4'd9;
  localparam logic [3:0] HOURONE_MAX_20 = 4'd3;
  localparam logic [3:0] MINDEC_MAX     = 4'd5;
  localparam logic [3:0] MINONE_MAX     = 4'd9;

  localparam int NUM_BTN   = 4;
  localparam int BTN_MODE  = 0;
  localparam int BTN_NEXT  = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_ALARM = 3;

  function automatic logic [3:0] bcd_inc(input logic [3:0] v, input logic [3:0] max);
    return (v >= max) ? 4'd0 : v + 4'd1;
  endfunction

  // Entering the 20s pulls hourone down so the edit never shows 24..29.
  function automatic time_t edit_inc(input time_t e, input digit_e idx);
    time_t r;
    r = e;
    case (idx)
      D_HOURDEC: begin
        r[3] = bcd_inc(e[3], HOURDEC_MAX);
        if (r[3] == HOURDEC_MAX && r[2] > HOURONE_MAX_20) r[2] = HOURONE_MAX_20;
      end
      D_HOURONE: r[2] = bcd_inc(e[2], (e[3] == HOURDEC_MAX) ? HOURONE_MAX_20 : HOURONE_MAX);
      D_MINDEC:  r[1] = bcd_inc(e[1], MINDEC_MAX);
      D_MINONE:  r[0] = bcd_inc(e[0], MINONE_MAX);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Raw button -> one-cycle press pulse: 2-FF sync, optional debounce, rising edge.
// Debounce filter is built only when ALARM_SET_DEBOUNCE_EN is defined.
module btn_cond #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_i,
  output logic press_o
);

  logic [1:0] sync_q;
  logic       lvl;
  logic       lvl_prev_q;
  logic       press_q;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[0], btn_i};
  end

`ifdef ALARM_SET_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          filt_q;

  // Any disagreement with the filtered level must persist unbroken to be accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[1] == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_q  <= '0;
      filt_q <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
  assign lvl = filt_q;
`else
  assign lvl = sync_q[1];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lvl_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      lvl_prev_q <= lvl;
      press_q    <= lvl & ~lvl_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alarm_set_ctrl.sv
// Button-driven editor for current time and alarm (bud) time plus alarm enable.
// Define ALARM_SET_DEBOUNCE_EN to insert the per-button debounce filter.
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_alarm,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  output logic [3:0] hourdec_init,
  output logic [3:0] hourone_init,
  output logic [3:0] mindec_init,
  output logic [3:0] minone_init,
  output logic       load_time,
  output logic [3:0] hourdec_bud,
  output logic [3:0] hourone_bud,
  output logic [3:0] mindec_bud,
  output logic [3:0] minone_bud,
  output logic       bud_en,
  output logic [1:0] set_mode,
  output logic [3:0] digit_sel
);

  logic [NUM_BTN-1:0] btn_raw, press;

  assign btn_raw = {btn_alarm, btn_up, btn_next, btn_mode};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk    (clk),
      .rstn   (rstn),
      .btn_i  (btn_raw[b]),
      .press_o(press[b])
    );
  end

  mode_e      mode_q, mode_d;
  digit_e     idx_q, idx_d;
  time_t      edit_q, edit_d, init_q, init_d, bud_q, bud_d;
  logic       bud_en_q, bud_en_d;
  logic       load_q, load_d;
  logic [3:0] digit_sel_q, digit_sel_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q      <= RUN;
      idx_q       <= D_HOURDEC;
      edit_q      <= '0;
      init_q      <= '0;
      bud_q       <= '0;
      bud_en_q    <= 1'b0;
      load_q      <= 1'b0;
      digit_sel_q <= '0;
    end else begin
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      edit_q      <= edit_d;
      init_q      <= init_d;
      bud_q       <= bud_d;
      bud_en_q    <= bud_en_d;
      load_q      <= load_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    idx_d    = idx_q;
    edit_d   = edit_q;
    init_d   = init_q;
    bud_d    = bud_q;
    bud_en_d = bud_en_q;
    load_d   = 1'b0;
    case (mode_q)
      RUN: begin
        if (press[BTN_MODE]) begin
          edit_d = {hourdec_now, hourone_now, mindec_now, minone_now};
          idx_d  = D_HOURDEC;
          mode_d = SET_TIME;
        end
        if (press[BTN_ALARM]) bud_en_d = ~bud_en_q;
      end
      SET_TIME, SET_BUD: begin
        // mode > next > up; a lower-priority press in the same cycle is dropped.
        if (press[BTN_MODE]) begin
          if (mode_q == SET_TIME) begin
            edit_d = bud_q;
            idx_d  = D_HOURDEC;
            mode_d = SET_BUD;
          end else begin
            mode_d = RUN;
          end
        end else if (press[BTN_NEXT]) begin
          if (idx_q == D_MINONE) begin
            if (mode_q == SET_TIME) begin
              init_d = edit_q;
              load_d = 1'b1;
            end else begin
              bud_d = edit_q;
            end
            mode_d = RUN;
          end else begin
            idx_d = digit_e'(idx_q + 2'd1);
          end
        end else if (press[BTN_UP]) begin
          edit_d = edit_inc(edit_q, idx_q);
        end
      end
      default: mode_d = RUN;
    endcase
    digit_sel_d = (mode_d == RUN) ? 4'b0000 : (4'b1000 >> idx_d);
  end

  assign {hourdec_init, hourone_init, mindec_init, minone_init} = init_q;
  assign {hourdec_bud, hourone_bud, mindec_bud, minone_bud}     = bud_q;
  assign load_time = load_q;
  assign bud_en    = bud_en_q;
  assign set_mode  = mode_q;
  assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Scoreboard bench for alarm_set_ctrl: expected init/bud/bud_en values are queued
// when the committing press is driven and popped when the DUT shows the change.
module tb_alarm_set_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       btn_mode, btn_next, btn_up, btn_alarm;
  logic [15:0] now;
  logic [3:0] hourdec_init, hourone_init, mindec_init, minone_init;
  logic [3:0] hourdec_bud, hourone_bud, mindec_bud, minone_bud;
  logic       load_time, bud_en;
  logic [1:0] set_mode;
  logic [3:0] digit_sel;

  alarm_set_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .btn_mode    (btn_mode),
    .btn_next    (btn_next),
    .btn_up      (btn_up),
    .btn_alarm   (btn_alarm),
    .hourdec_now (now[15:12]),
    .hourone_now (now[11:8]),
    .mindec_now  (now[7:4]),
    .minone_now  (now[3:0]),
    .hourdec_init(hourdec_init),
    .hourone_init(hourone_init),
    .mindec_init (mindec_init),
    .minone_init (minone_init),
    .load_time   (load_time),
    .hourdec_bud (hourdec_bud),
    .hourone_bud (hourone_bud),
    .mindec_bud  (mindec_bud),
    .minone_bud  (minone_bud),
    .bud_en      (bud_en),
    .set_mode    (set_mode),
    .digit_sel   (digit_sel)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] M = 4'b0001, N = 4'b0010, U = 4'b0100, A = 4'b1000;

  logic [15:0] init_w, bud_w, prev_bud;
  logic        prev_en;
  int          n_cmp = 0, n_err = 0, load_cnt = 0;
  logic [15:0] q_init[$], q_bud[$];
  logic        q_en[$];

  assign init_w = {hourdec_init, hourone_init, mindec_init, minone_init};
  assign bud_w  = {hourdec_bud, hourone_bud, mindec_bud, minone_bud};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Raw button held 5 cycles then released 4; the FSM has reacted by return.
  task automatic press(input logic [3:0] b);
    @(posedge clk); #1;
    {btn_alarm, btn_up, btn_next, btn_mode} = b;
    repeat (5) @(posedge clk);
    #1 {btn_alarm, btn_up, btn_next, btn_mode} = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic press_n(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (load_time) begin
        load_cnt++;
        chk("init_avail", 32'(q_init.size() != 0), 32'd1);
        if (q_init.size() != 0) chk("init", init_w, q_init.pop_front());
      end
      if (bud_w !== prev_bud) begin
        chk("bud_avail", 32'(q_bud.size() != 0), 32'd1);
        if (q_bud.size() != 0) chk("bud", bud_w, q_bud.pop_front());
      end
      if (bud_en !== prev_en) begin
        chk("en_avail", 32'(q_en.size() != 0), 32'd1);
        if (q_en.size() != 0) chk("bud_en", bud_en, q_en.pop_front());
      end
    end
    prev_bud = bud_w;
    prev_en  = bud_en;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    {btn_alarm, btn_up, btn_next, btn_mode} = 4'b0000;
    now = 16'h0000;
    #23;
    chk("rst_init", init_w, 16'h0000);
    chk("rst_bud", bud_w, 16'h0000);
    chk("rst_misc", {bud_en, load_time, set_mode, digit_sel}, 8'h00);
    @(negedge clk) rstn = 1'b1;

    // alarm toggles in RUN
    q_en.push_back(1'b1); press(A);
    q_en.push_back(1'b0); press(A);
    chk("alm_mode", set_mode, 2'd0);
    chk("alm_sel", digit_sel, 4'd0);
    chk("alm_init", init_w, 16'h0000);
    chk("alm_bud", bud_w, 16'h0000);

    // 13:47 -> 23:57
    now = 16'h1347;
    press(M);
    chk("st_mode", set_mode, 2'd1);
    chk("st_sel0", digit_sel, 4'b1000);
    press(U); press(N);
    chk("st_sel1", digit_sel, 4'b0100);
    press(N); press(U); press(N);
    chk("st_sel3", digit_sel, 4'b0001);
    q_init.push_back(16'h2357); press(N);
    chk("st_back_run", set_mode, 2'd0);
    chk("st_sel_run", digit_sel, 4'd0);
    chk("st_load1", load_cnt, 1);

    // 19:00: clamp to 23, mindec to 5
    now = 16'h1900;
    press(M); press(U); press(N); press(N); press_n(U, 5); press(N);
    q_init.push_back(16'h2350); press(N);
    // hourone wraps 3->0, mindec wraps 5->0
    press(M); press(U); press(N); press(U); press(N); press_n(U, 6); press(N);
    q_init.push_back(16'h2000); press(N);
    chk("clamp_load3", load_cnt, 3);

    // SET_BUD commit 00:02
    press(M); press(M);
    chk("sb_mode", set_mode, 2'd2);
    chk("sb_sel0", digit_sel, 4'b1000);
    press_n(N, 3);
    chk("sb_sel3", digit_sel, 4'b0001);
    press_n(U, 2);
    q_bud.push_back(16'h0002); press(N);
    chk("sb_run", set_mode, 2'd0);
    chk("sb_en", bud_en, 1'b0);
    chk("sb_noload", load_cnt, 3);

    // mode+up together: mode wins, no increment
    press(M);
    press(M | U);
    chk("pri_mode", set_mode, 2'd2);
    chk("pri_sel", digit_sel, 4'b1000);
    press_n(N, 3); press(U);
    q_bud.push_back(16'h0003); press(N);
    // abort mid-SET_BUD
    press(M); press(M); press(U); press(M);
    chk("abort_run", set_mode, 2'd0);
    chk("abort_bud", bud_w, 16'h0003);
    chk("abort_init", init_w, 16'h2000);

    // async reset at index 2 of SET_BUD
    q_en.push_back(1'b1); press(A);
    press(M); press(M); press(N); press(N);
    chk("pre_rst_sel", digit_sel, 4'b0010);
    chk("pre_rst_mode", set_mode, 2'd2);
    #3 rstn = 1'b0;
    #1;
    chk("arst_init", init_w, 16'h0000);
    chk("arst_bud", bud_w, 16'h0000);
    chk("arst_misc", {bud_en, load_time, set_mode, digit_sel}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_mode", set_mode, 2'd0);
    chk("post_rst_sel", digit_sel, 4'd0);

    chk("q_init_left", q_init.size(), 0);
    chk("q_bud_left", q_bud.size(), 0);
    chk("q_en_left", q_en.size(), 0);
    chk("load_total", load_cnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
